// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: handshake/status bundle between the producer/consumer
// logic and the circular-buffer pointer controller.
//   master : drives clk_en/Flush/Push/Pop/ErrClr, observes strobes and status
//   slave  : the controller; observes requests, drives strobes, addresses,
//            Round, Count, Full/Empty/AlmostFull/AlmostEmpty, Overflow/Underflow
interface fifo_ptr_ctrl_if #(
  parameter int BufferWidth = 4
);
  logic                   clk_en;
  logic                   Flush;
  logic                   Push;
  logic                   Pop;
  logic                   ErrClr;
  logic                   W_En;
  logic                   R_En;
  logic [BufferWidth-1:0] W_Addr;
  logic [BufferWidth-1:0] R_Addr;
  logic                   Round;
  logic [BufferWidth:0]   Count;
  logic                   Full;
  logic                   Empty;
  logic                   AlmostFull;
  logic                   AlmostEmpty;
  logic                   Overflow;
  logic                   Underflow;

  modport master (
    output clk_en, Flush, Push, Pop, ErrClr,
    input  W_En, R_En, W_Addr, R_Addr, Round, Count,
    input  Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow
  );

  modport slave (
    input  clk_en, Flush, Push, Pop, ErrClr,
    output W_En, R_En, W_Addr, R_Addr, Round, Count,
    output Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: write/read pointer and status controller for an external
// dual-port buffer RAM of BufferSize entries (non-power-of-two allowed).
//   clk  : single clock, rising edge
//   aclr : synchronous active-high reset
//   bus  : fifo_ptr_ctrl_if.slave
//          W_En/R_En combinational accept strobes; W_Addr/R_Addr, Round,
//          Count and all flags registered; Overflow/Underflow sticky.
module fifo_ptr_ctrl #(
  parameter int BufferWidth    = 4,
  parameter int BufferSize     = 16,
  parameter int AlmostFullThr  = 12,
  parameter int AlmostEmptyThr = 4
) (
  input  logic         clk,
  input  logic         aclr,
  fifo_ptr_ctrl_if.slave bus
);

  localparam logic [BufferWidth-1:0] LP_LAST = BufferWidth'(BufferSize - 1);
  localparam logic [BufferWidth:0]   LP_SIZE = (BufferWidth+1)'(BufferSize);
  localparam logic [BufferWidth:0]   LP_AF   = (BufferWidth+1)'(AlmostFullThr);
  localparam logic [BufferWidth:0]   LP_AE   = (BufferWidth+1)'(AlmostEmptyThr);
  localparam logic                   LP_AF_RST = (AlmostFullThr == 0);

  logic [BufferWidth-1:0] r_waddr, r_raddr;
  logic                   r_round;
  logic [BufferWidth:0]   r_count;
  logic                   r_full, r_empty, r_afull, r_aempty;
  logic                   r_ovf, r_udf;

  logic                   w_w_en, w_r_en;
  logic                   w_w_wrap, w_r_wrap;
  logic [BufferWidth-1:0] w_waddr_nxt, w_raddr_nxt;
  logic                   w_round_nxt;
  logic [BufferWidth:0]   w_count_nxt;
  logic                   w_ovf_set, w_udf_set;

  // Pop is never bypassed through an empty buffer; push while full needs a
  // simultaneous accepted pop. Both strobes are killed during reset.
  always_comb begin
    w_r_en = bus.clk_en & bus.Pop & ~r_empty & ~bus.Flush & ~aclr;
    w_w_en = bus.clk_en & bus.Push & ~bus.Flush & (~r_full | w_r_en) & ~aclr;
  end

  always_comb begin
    w_w_wrap    = w_w_en & (r_waddr == LP_LAST);
    w_r_wrap    = w_r_en & (r_raddr == LP_LAST);
    w_waddr_nxt = r_waddr;
    w_raddr_nxt = r_raddr;
    if (w_w_en) w_waddr_nxt = w_w_wrap ? '0 : r_waddr + 1'b1;
    if (w_r_en) w_raddr_nxt = w_r_wrap ? '0 : r_raddr + 1'b1;
    // Simultaneous wraps on both sides keep the lap difference unchanged.
    w_round_nxt = r_round ^ (w_w_wrap ^ w_r_wrap);
    w_count_nxt = r_count;
    if (w_w_en & ~w_r_en)      w_count_nxt = r_count + 1'b1;
    else if (~w_w_en & w_r_en) w_count_nxt = r_count - 1'b1;
    w_ovf_set = bus.clk_en & bus.Push & ~w_w_en & ~bus.Flush;
    w_udf_set = bus.clk_en & bus.Pop  & ~w_r_en & ~bus.Flush;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_round  <= 1'b0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= LP_AF_RST;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.clk_en) begin
      if (bus.Flush) begin
        r_waddr  <= '0;
        r_raddr  <= '0;
        r_round  <= 1'b0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
        r_afull  <= LP_AF_RST;
        r_aempty <= 1'b1;
      end else begin
        // Flags come from the next-state count so they line up with the
        // pointers registered on the same edge.
        r_waddr  <= w_waddr_nxt;
        r_raddr  <= w_raddr_nxt;
        r_round  <= w_round_nxt;
        r_count  <= w_count_nxt;
        r_full   <= (w_count_nxt == LP_SIZE);
        r_empty  <= (w_count_nxt == '0);
        r_afull  <= (w_count_nxt >= LP_AF);
        r_aempty <= (w_count_nxt <= LP_AE);
      end
      // A set event in the same cycle as ErrClr wins.
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (bus.ErrClr) r_ovf <= 1'b0;
      if (w_udf_set)       r_udf <= 1'b1;
      else if (bus.ErrClr) r_udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      assert (r_full  == ((r_waddr == r_raddr) &  r_round));
      assert (r_empty == ((r_waddr == r_raddr) & ~r_round));
      assert (r_full  == (r_count == LP_SIZE));
      assert (r_empty == (r_count == '0));
    end
  end

  assign bus.W_En        = w_w_en;
  assign bus.R_En        = w_r_en;
  assign bus.W_Addr      = r_waddr;
  assign bus.R_Addr      = r_raddr;
  assign bus.Round       = r_round;
  assign bus.Count       = r_count;
  assign bus.Full        = r_full;
  assign bus.Empty       = r_empty;
  assign bus.AlmostFull  = r_afull;
  assign bus.AlmostEmpty = r_aempty;
  assign bus.Overflow    = r_ovf;
  assign bus.Underflow   = r_udf;

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised circular-buffer pointer and status controller: generates write/read addresses for an external dual-port buffer RAM and tracks occupancy with a lap (Round) bit, full/empty, almost-full/almost-empty thresholds, a live count and sticky overflow/underflow errors. It extends the single Round flag used by the convolution engine's line buffers into a complete controller. Non-power-of-two depths are supported. It sits between the Avalon-side producer/consumer logic and the buffer RAM.

## Interface
- BufferWidth, 4, address width; requires 2^BufferWidth >= BufferSize.
- BufferSize, 16, depth in entries; legal range 2..2^BufferWidth.
- AlmostFullThr, 12, AlmostFull asserts when Count >= AlmostFullThr; range 1..BufferSize.
- AlmostEmptyThr, 4, AlmostEmpty asserts when Count <= AlmostEmptyThr; range 0..BufferSize-1.

- clk  in  1  single clock; all state changes on the rising edge.
- aclr  in  1  reset, synchronous, active-high.
- clk_en  in  1  global enable; when low, Push/Pop/Flush/ErrClr are ignored and all state holds.
- Flush  in  1  synchronous empty request.
- Push  in  1  write request.
- Pop  in  1  read request.
- ErrClr  in  1  clears Overflow/Underflow.
- W_En  out  1  push accepted this cycle (combinational); RAM write strobe.
- R_En  out  1  pop accepted this cycle (combinational).
- W_Addr  out  BufferWidth  registered write pointer.
- R_Addr  out  BufferWidth  registered read pointer.
- Round  out  1  registered; 1 when the write pointer is one lap ahead of the read pointer.
- Count  out  BufferWidth+1  registered occupancy, 0..BufferSize.
- Full, Empty, AlmostFull, AlmostEmpty  out  1 each  registered status.
- Overflow, Underflow  out  1 each  registered sticky errors.

## Operation
- Reset values: W_Addr=0, R_Addr=0, Round=0, Count=0, Empty=1, Full=0, AlmostEmpty=1, AlmostFull=(AlmostFullThr==0 ? 1 : 0, i.e. 0 for legal params), Overflow=0, Underflow=0.
- Priority per edge: aclr > Flush > push/pop.
- R_En = clk_en & Pop & !Empty & !Flush. No bypass: a pop while Empty is rejected even if Push is high.
- W_En = clk_en & Push & !Flush & (!Full | R_En). Push while Full is accepted only if a pop is accepted the same cycle.
- Pointer advance: on accept, pointer increments; at BufferSize-1 it wraps to 0 (not 2^BufferWidth-1).
- Round toggles on each write wrap and each read wrap; both wrapping the same cycle leaves Round unchanged.
- Full = (W_Addr==R_Addr) & Round; Empty = (W_Addr==R_Addr) & !Round; both must equal Count==BufferSize / Count==0 at all times (assertion).
- Count: +1 on W_En only, -1 on R_En only, unchanged on both or neither.
- Flush (with clk_en): W_Addr, R_Addr, Round, Count to reset values; errors untouched.
- Overflow sets when clk_en & Push & !W_En & !Flush; Underflow sets when clk_en & Pop & !R_En & !Flush. ErrClr clears; a set event in the same cycle wins.
- Status flags are computed from the next-state count and registered, so they are valid in the same cycle as the pointers they describe.

## Timing
- Accept strobes W_En/R_En: zero latency, combinational from inputs and registered state. There is no combinational path from Push to R_En or from Pop to W_En, except the Full & Pop case into W_En.
- Pointers, Count and flags update on the edge where the accept is high. A word written at edge N is poppable from cycle N+1 because Empty deasserts after edge N.
- The RAM reads R_Addr, which is valid in the cycle R_En is asserted. Read-data latency belongs to the RAM.
- aclr mid-operation: all state returns to reset values at that edge and accept strobes are forced low while aclr is high.

## Test plan
- Reset, then 16 pushes (defaults) -> W_Addr wraps 15->0, Round=1, Full=1, Count=16, AlmostFull from Count=12; 17th push -> W_En=0, Overflow=1, W_Addr stays 0.
- Full, Push=Pop=1 for 3 cycles -> W_En=R_En=1, Count stays 16, R_Addr 0->3, W_Addr 0->3, Full stays 1.
- Empty, Push=Pop=1 -> W_En=1, R_En=0, Underflow=1, Count=1; ErrClr -> Underflow=0 next edge.
- BufferSize=12, BufferWidth=4: 30 push/pop pairs offset by 5 entries -> pointers never exceed 11, Count constant at 5, Round toggles at each lap.
- Count=7, Flush with Push=1 -> next cycle Count=0, Empty=1, pointers 0, no Overflow.
- aclr asserted mid-burst at Count=9 with Push=1 -> next cycle all outputs at reset values; clk_en=0 for 4 cycles with Push=1 -> no state change.
